// File: rtl/epp_regfile.sv
// EPP slave with an 8-bit register file, command strobes and a busy/overrun status register.
// The host strobes and direction pass through synchronisers, and a two-state FSM drives EppWait.
module epp_regfile #(
    parameter int         NUM_REGS    = 12,
    parameter int         NUM_CMDS    = 2,
    parameter logic [7:0] STATUS_ADDR = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  EppAstb,
    input  logic                  EppDstb,
    input  logic                  EppWR,
    output logic                  EppWait,
    inout  wire  [7:0]            EppDB,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic [NUM_CMDS-1:0]   cmd_strobe,
    output logic [7:0]            cmd_data,
    input  logic                  busy
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] astb_sync_reg;
    logic [SYNC_STAGES-1:0] dstb_sync_reg;
    logic [SYNC_STAGES-1:0] wr_sync_reg;
    logic [7:0]             address_reg;
    logic [7:0]             rdata_reg;
    logic                   wr_cap_reg;
    logic                   overrun_reg;
    logic [7:0]             regs_reg [NUM_REGS];

    logic                   as_s;
    logic                   ds_s;
    logic                   wr_s;
    logic                   data_wr;
    logic                   data_rd;
    logic [NUM_REGS-1:0]    reg_hit;
    logic [NUM_CMDS-1:0]    cmd_hit;
    logic [7:0]             read_mux;

    assign as_s = astb_sync_reg[SYNC_STAGES-1];
    assign ds_s = dstb_sync_reg[SYNC_STAGES-1];
    assign wr_s = wr_sync_reg[SYNC_STAGES-1];

    // The address strobe takes priority, so a data access only fires when as is high.
    assign data_wr = (state_reg == IDLE) && as_s && !ds_s && !wr_s;
    assign data_rd = (state_reg == IDLE) && as_s && !ds_s && wr_s;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign reg_hit[gi]            = (address_reg == 8'(gi));
            assign regs_flat[8*gi +: 8]   = regs_reg[gi];
        end
        for (gi = 0; gi < NUM_CMDS; gi++) begin : g_cmd
            assign cmd_hit[gi] = (address_reg == 8'(NUM_REGS + gi));
        end
    endgenerate

    always_comb begin
        read_mux = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_hit[i]) begin
                read_mux = regs_reg[i];
            end
        end
        if (address_reg == STATUS_ADDR) begin
            read_mux = {6'b0, overrun_reg, busy};
        end
    end

    assign EppDB = (state_reg == ACK && wr_cap_reg) ? rdata_reg : 8'bz;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            astb_sync_reg <= '1;
            dstb_sync_reg <= '1;
            wr_sync_reg   <= '1;
        end else begin
            astb_sync_reg <= {astb_sync_reg[SYNC_STAGES-2:0], EppAstb};
            dstb_sync_reg <= {dstb_sync_reg[SYNC_STAGES-2:0], EppDstb};
            wr_sync_reg   <= {wr_sync_reg[SYNC_STAGES-2:0], EppWR};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= 8'h00;
            end
        end else if (data_wr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_hit[i]) begin
                    regs_reg[i] <= EppDB;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_strobe <= '0;
            cmd_data   <= 8'h00;
        end else begin
            cmd_strobe <= '0;
            if (data_wr && |cmd_hit && !busy) begin
                cmd_strobe <= cmd_hit;
                cmd_data   <= EppDB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            EppWait     <= 1'b0;
            address_reg <= 8'h00;
            rdata_reg   <= 8'h00;
            wr_cap_reg  <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!as_s || !ds_s) begin
                        state_reg  <= ACK;
                        EppWait    <= 1'b1;
                        wr_cap_reg <= wr_s;
                        if (!as_s) begin
                            if (wr_s) rdata_reg   <= address_reg;
                            else      address_reg <= EppDB;
                        end else if (wr_s) begin
                            rdata_reg <= read_mux;
                        end
                    end
                end
                ACK: begin
                    if (as_s && ds_s) begin
                        state_reg <= IDLE;
                        EppWait   <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            // Set is evaluated last so it wins over a clear in the same clock.
            if (data_rd && address_reg == STATUS_ADDR) begin
                overrun_reg <= 1'b0;
            end
            if (data_wr && |cmd_hit && busy) begin
                overrun_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_epp_regfile.sv
// Bench for epp_regfile: a transaction-level model predicts every output on every cycle,
// with directed cases pinned to literal values and a randomized transaction run.
module tb_epp_regfile;

    localparam int         NR  = 12;
    localparam int         NC  = 2;
    localparam int         SS  = 2;
    localparam logic [7:0] SA  = 8'hFF;
    localparam int         LAT = SS + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic astb = 1'b1;
    logic dstb = 1'b1;
    logic wr = 1'b1;
    logic busy = 1'b0;
    logic host_drive = 1'b0;
    logic [7:0] host_data = 8'h00;

    tri1  [7:0]      epp_db;
    logic            epp_wait;
    logic [NR*8-1:0] regs_flat;
    logic [NC-1:0]   cmd_strobe;
    logic [7:0]      cmd_data;

    assign epp_db = host_drive ? host_data : 8'bz;

    epp_regfile #(.NUM_REGS(NR), .NUM_CMDS(NC), .STATUS_ADDR(SA), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .EppAstb(astb), .EppDstb(dstb), .EppWR(wr),
        .EppWait(epp_wait), .EppDB(epp_db), .regs_flat(regs_flat),
        .cmd_strobe(cmd_strobe), .cmd_data(cmd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model state
    logic [7:0]    m_regs [NR];
    logic [7:0]    m_addr;
    logic          m_overrun;
    logic [7:0]    m_cmd_data;
    logic          exp_wait;
    logic          exp_drive;
    logic [7:0]    exp_rdata;
    logic [NC-1:0] exp_strobe;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        m_addr = 8'h00; m_overrun = 1'b0; m_cmd_data = 8'h00;
        exp_wait = 1'b0; exp_drive = 1'b0; exp_rdata = 8'h00; exp_strobe = '0;
    endtask

    // One access as the host sees it: what it returns and what it changes.
    task automatic model_access(input bit is_addr, input bit rd, input logic [7:0] d,
                                output logic [7:0] rv);
        rv = 8'h00;
        if (is_addr) begin
            if (rd) rv = m_addr;
            else    m_addr = d;
        end else if (rd) begin
            if (int'(m_addr) < NR) rv = m_regs[m_addr];
            else if (m_addr == SA) begin
                rv = {6'b0, m_overrun, busy};
                m_overrun = 1'b0;
            end
        end else begin
            if (int'(m_addr) < NR) m_regs[m_addr] = d;
            else if (int'(m_addr) < NR + NC) begin
                if (!busy) begin
                    exp_strobe[int'(m_addr) - NR] = 1'b1;
                    m_cmd_data = d;
                end else begin
                    m_overrun = 1'b1;
                end
            end
        end
    endtask

    // The compare point: every negedge, every output against the model.
    task automatic tick();
        logic [NR*8-1:0] exp_flat;
        logic [7:0]      exp_bus;
        @(negedge clk);
        for (int i = 0; i < NR; i++) exp_flat[8*i +: 8] = m_regs[i];
        exp_bus = host_drive ? host_data : (exp_drive ? exp_rdata : 8'hFF);
        check("wait", 32'(epp_wait), 32'(exp_wait));
        check("bus", 32'(epp_db), 32'(exp_bus));
        check("strobe", 32'(cmd_strobe), 32'(exp_strobe));
        check("cmd_data", 32'(cmd_data), 32'(m_cmd_data));
        checks++;
        if (regs_flat !== exp_flat) begin
            errors++;
            $display("FAIL regs actual %h required %h at %0t", regs_flat, exp_flat, $time);
        end
    endtask

    task automatic xact(input bit is_addr, input bit rd, input logic [7:0] d, input int hold,
                        output logic [7:0] got);
        logic [7:0] rv;
        got = 8'h00;
        wr = rd; host_drive = !rd; host_data = d;
        if (is_addr) astb = 1'b0; else dstb = 1'b0;
        for (int k = 1; k <= LAT + hold; k++) begin
            if (k == LAT) begin
                model_access(is_addr, rd, d, rv);
                exp_wait = 1'b1; exp_drive = rd; exp_rdata = rv;
            end
            if (k == LAT + 1) exp_strobe = '0;
            tick();
            if (k == LAT) got = epp_db;
        end
        astb = 1'b1; dstb = 1'b1; host_drive = 1'b0; exp_strobe = '0;
        for (int k = 1; k <= SS + 1; k++) begin
            if (k == SS + 1) begin exp_wait = 1'b0; exp_drive = 1'b0; end
            tick();
        end
        $display("xact %s %s data %h got %h busy %0d", is_addr ? "addr" : "data",
                 rd ? "rd" : "wr", d, got, busy);
    endtask

    initial begin
        logic [7:0] g;
        logic [7:0] a;
        int kind;
        model_reset();
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        tick();

        // Register write and read-back
        xact(1, 0, 8'h04, 1, g);
        xact(0, 0, 8'hA5, 1, g);
        xact(0, 1, 8'h00, 1, g);
        check("read_reg4", 32'(g), 32'h0000_00A5);
        check("flat_reg4", 32'(regs_flat[39:32]), 32'h0000_00A5);
        xact(1, 1, 8'h00, 1, g);
        check("addr_read", 32'(g), 32'h0000_0004);

        // Command strobe, then overrun with busy high
        xact(1, 0, 8'(NR), 1, g);
        xact(0, 0, 8'h01, 2, g);
        check("cmd_data_lit", 32'(cmd_data), 32'h0000_0001);
        busy = 1'b1;
        xact(0, 0, 8'h02, 1, g);
        xact(1, 0, SA, 1, g);
        xact(0, 1, 8'h00, 1, g);
        check("status_busy", 32'(g), 32'h0000_0003);
        busy = 1'b0;
        xact(0, 1, 8'h00, 1, g);
        check("status_clear", 32'(g), 32'h0000_0000);
        check("cmd_data_kept", 32'(cmd_data), 32'h0000_0001);

        // Long strobe: one write, Wait held until release
        xact(1, 0, 8'h00, 1, g);
        xact(0, 0, 8'h5A, 50, g);
        check("hold_reg0", 32'(regs_flat[7:0]), 32'h0000_005A);

        // Reset in the middle of a read acknowledge
        xact(1, 0, 8'h04, 1, g);
        wr = 1'b1; dstb = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            if (k == LAT) begin exp_wait = 1'b1; exp_drive = 1'b1; exp_rdata = m_regs[4]; end
            tick();
        end
        rst_n = 1'b0;
        model_reset();
        tick();
        dstb = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        xact(0, 0, 8'h3C, 1, g);
        xact(0, 1, 8'h00, 1, g);
        check("after_reset", 32'(g), 32'h0000_003C);

        // Randomized transactions
        for (int n = 0; n < 300; n++) begin
            busy = ($urandom_range(0, 3) == 0);
            kind = int'($urandom_range(0, 9));
            if (kind < 3) begin
                a = ($urandom_range(0, 7) == 0) ? SA : 8'($urandom_range(0, 15));
                xact(1, 0, a, int'($urandom_range(1, 4)), g);
            end else if (kind == 3) begin
                xact(1, 1, 8'h00, int'($urandom_range(1, 4)), g);
            end else if (kind < 7) begin
                xact(0, 0, 8'($urandom), int'($urandom_range(1, 4)), g);
            end else begin
                xact(0, 1, 8'h00, int'($urandom_range(1, 4)), g);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
